// File: rtl/serial_pattern_counter.sv
// rtl/serial_pattern_counter.sv - serial bit-pattern detector with wrapping match counter
module serial_pattern_counter #(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
  parameter int                     OUT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data,
  output logic [OUT_W-1:0] out
);

  localparam int                FILL_W   = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [OUT_W-1:0]       cnt_q,  cnt_d;
  logic                   match;

  // Next-state: shift the new bit in at the LSB, saturate the fill count,
  // and compare the window that already contains this edge's bit.
  always_comb begin
    hist_d = {hist_q[PATTERN_LEN-2:0], data};
    fill_d = fill_q;
    if (fill_q != FILL_MAX) begin
      fill_d = fill_q + 1'b1;
    end
    match = (fill_d == FILL_MAX) && (hist_d == PATTERN);
    cnt_d = cnt_q;
    if (match) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards history, fill progress and the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: tb/tb_serial_pattern_counter.sv
// tb/tb_serial_pattern_counter.sv - directed self-checking bench for serial_pattern_counter
module tb_serial_pattern_counter;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic [2:0] out;

  int n_total;
  int n_bad;

  serial_pattern_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: present bit, let one rising edge sample it,
  // check the registered count, then return on the next falling edge.
  task automatic send_chk(input logic b, input logic [2:0] exp, input string tag);
    data = b;
    @(posedge clk);
    #1;
    check_eq(tag, out, exp);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges; out must clear at once
  // and stay clear across an edge with data driven high.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_async"}, out, 3'd0);
    data = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_held"}, out, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    data    = 1'b1;

    // Reset held from time zero with data toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = ~data;
      check_eq("reset_hold", out, 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed stream 1,0,1,0,0,1,0,1 then 40 ones
    send_chk(1'b1, 3'd0, "dir_e1");
    send_chk(1'b0, 3'd0, "dir_e2");
    send_chk(1'b1, 3'd1, "dir_e3");
    send_chk(1'b0, 3'd1, "dir_e4");
    send_chk(1'b0, 3'd1, "dir_e5");
    send_chk(1'b1, 3'd1, "dir_e6");
    send_chk(1'b0, 3'd1, "dir_e7");
    send_chk(1'b1, 3'd2, "dir_e8");
    for (int i = 0; i < 40; i++) begin
      send_chk(1'b1, 3'd2, "dir_ones");
    end

    // Overlap: 1,0,1,0,1,0,1
    pulse_reset("rst_ovl");
    send_chk(1'b1, 3'd0, "ovl_e1");
    send_chk(1'b0, 3'd0, "ovl_e2");
    send_chk(1'b1, 3'd1, "ovl_e3");
    send_chk(1'b0, 3'd1, "ovl_e4");
    send_chk(1'b1, 3'd2, "ovl_e5");
    send_chk(1'b0, 3'd2, "ovl_e6");
    send_chk(1'b1, 3'd3, "ovl_e7");

    // Wrap: 1 then (0,1) pairs, each pair completes one match
    pulse_reset("rst_wrap");
    send_chk(1'b1, 3'd0, "wrap_lead");
    for (int k = 1; k <= 9; k++) begin
      send_chk(1'b0, 3'((k - 1) % 8), "wrap_zero");
      send_chk(1'b1, 3'(k % 8), "wrap_match");
    end

    // Output is registered: changing data between edges must not move out
    data = 1'b0;
    #2;
    check_eq("no_comb_path", out, 3'd1);

    // Fill guard: history preloaded with 1,0 before reset, then a single 1
    pulse_reset("rst_fill_a");
    send_chk(1'b1, 3'd0, "fill_pre1");
    send_chk(1'b0, 3'd0, "fill_pre0");
    pulse_reset("rst_fill_b");
    send_chk(1'b1, 3'd0, "fill_post1");
    send_chk(1'b0, 3'd0, "fill_post2");
    send_chk(1'b1, 3'd1, "fill_post3");

    // Mid-pattern reset after a match has already been counted
    send_chk(1'b0, 3'd1, "mid_pre0");
    send_chk(1'b1, 3'd2, "mid_pre1");
    send_chk(1'b0, 3'd2, "mid_pre2");
    pulse_reset("rst_mid");
    send_chk(1'b1, 3'd0, "mid_e1");
    send_chk(1'b0, 3'd0, "mid_e2");
    send_chk(1'b1, 3'd1, "mid_e3");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
